// File: rtl/mem_bus_responder.sv
// -----------------------------------------------------------------------------
// mem_bus_responder
//
// Memory-side endpoint of the CPU/MEM bus. It arbitrates the rq/gnt handshake
// and accepts a start pulse carrying mode and address. It then serves single
// or BURST_LEN-beat burst reads and writes from an internal DEPTH x DWIDTH RAM,
// with WAIT_STATES idle cycles between accepting start and the first beat.
// The data ports are split; the top level maps wdata/rdata/rdata_oe onto the
// shared inout data line.
//
// Optional feature macro:
//   MEM_BURST_EN  defined   : modes 10/11 run BURST_LEN-beat bursts.
//                 undefined : mode[1] is ignored, every transfer is one beat,
//                             and the beat counter is not built.
//
// Ports:
//   clk       in   1       bus clock; all logic on the rising edge
//   rst       in   1       synchronous, active-high reset
//   rq        in   1       master requests the bus
//   start     in   1       master launches a transfer (honoured only in GRANT)
//   mode      in   2       00 read, 01 write, 10 burst read, 11 burst write
//   addr      in   AWIDTH  start address, sampled with start
//   wdata     in   DWIDTH  write data, sampled on every rdy=1 cycle of a write
//   gnt       out  1       bus granted to master
//   rdy       out  1       one beat completes this cycle
//   rdata     out  DWIDTH  read data, valid when rdy=1 on a read
//   rdata_oe  out  1       drive enable for the shared data line (rdy on reads)
//
// All outputs are registered. The RAM contents are not cleared by reset.
// -----------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int DWIDTH      = 8,
    parameter int AWIDTH      = 8,
    parameter int WAIT_STATES = 1,
    parameter int BURST_LEN   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic              gnt,
    output logic              rdy,
    output logic [DWIDTH-1:0] rdata,
    output logic              rdata_oe
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [3:0]          wait_cnt_r;
    logic [3:0]          wait_nxt_s;
    logic [AWIDTH-1:0]   addr_r;       // address of the current beat
    logic                write_r;      // latched mode[0]
    logic                accept_s;     // start honoured this cycle
    logic                beat_done_s;  // a beat completes at this edge
    logic                last_beat_s;
    logic                nxt_write_s;
    logic [AWIDTH-1:0]   rd_addr_s;    // RAM word to present during the next cycle
    logic                we_s;
    logic                gnt_nxt_s;
    logic                rdy_nxt_s;
    logic                oe_nxt_s;

    logic [DWIDTH-1:0]   mem_r [DEPTH];

`ifdef MEM_BURST_EN
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);

    logic [BW-1:0] beat_r;
    logic          burst_r;       // latched mode[1]

    // A single transfer ends on its only beat; a burst on beat BURST_LEN-1.
    assign last_beat_s = !burst_r || (beat_r == BEAT_LAST);

    // Beat counter and burst flag: cleared on accept, advanced per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r  <= '0;
            burst_r <= 1'b0;
        end else if (accept_s) begin
            beat_r  <= '0;
            burst_r <= mode[1];
        end else if (beat_done_s) begin
            beat_r  <= last_beat_s ? '0 : beat_r + BEAT_ONE;
        end
    end
`else
    logic mode_unused_s;

    // Without bursts, every transfer is exactly one beat and mode[1] is a don't-care.
    assign last_beat_s   = 1'b1;
    assign mode_unused_s = mode[1];
`endif

    // Next-state, next-output and RAM address decode.
    always_comb begin
        next_state_s = state_r;
        wait_nxt_s   = wait_cnt_r;
        accept_s     = 1'b0;
        beat_done_s  = 1'b0;
        rd_addr_s    = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (rq) begin
                    next_state_s = ST_GRANT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // start wins over a simultaneous rq drop
                if (start) begin
                    accept_s  = 1'b1;
                    rd_addr_s = addr;
                    if (WAIT_INIT == 4'd0) begin
                        next_state_s = ST_XFER;
                        wait_nxt_s   = 4'd0;
                    end else begin
                        next_state_s = ST_WAIT;
                        wait_nxt_s   = WAIT_INIT;
                    end
                end else if (!rq) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_GRANT;
                end
            end
            ST_WAIT: begin
                // The counter holds the number of edges still to wait.
                if (wait_cnt_r <= 4'd1) begin
                    next_state_s = ST_XFER;
                    wait_nxt_s   = 4'd0;
                end else begin
                    next_state_s = ST_WAIT;
                    wait_nxt_s   = wait_cnt_r - 4'd1;
                end
            end
            ST_XFER: begin
                beat_done_s = 1'b1;
                rd_addr_s   = addr_r + ADDR_ONE;
                if (last_beat_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_XFER;
                end
            end
            ST_DONE: begin
                // Re-grant directly so gnt drops for exactly one cycle.
                if (rq) begin
                    next_state_s = ST_GRANT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                wait_nxt_s   = 4'd0;
            end
        endcase

        if (accept_s) begin
            nxt_write_s = mode[0];
        end else begin
            nxt_write_s = write_r;
        end

        gnt_nxt_s = (next_state_s == ST_GRANT) || (next_state_s == ST_WAIT) ||
                    (next_state_s == ST_XFER);
        rdy_nxt_s = (next_state_s == ST_XFER);
        oe_nxt_s  = rdy_nxt_s && !nxt_write_s;
    end

    assign we_s = (state_r == ST_XFER) && write_r;

    // Control state, latched request fields and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 4'd0;
            addr_r     <= '0;
            write_r    <= 1'b0;
            gnt        <= 1'b0;
            rdy        <= 1'b0;
            rdata      <= '0;
            rdata_oe   <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_nxt_s;
            if (accept_s) begin
                addr_r  <= addr;
                write_r <= mode[0];
            end else if (beat_done_s) begin
                addr_r  <= addr_r + ADDR_ONE;  // wraps modulo DEPTH
            end
            gnt      <= gnt_nxt_s;
            rdy      <= rdy_nxt_s;
            rdata_oe <= oe_nxt_s;
            rdata    <= oe_nxt_s ? mem_r[rd_addr_s] : '0;
        end
    end

    // RAM write port; a beat whose edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && we_s) begin
            mem_r[addr_r] <= wdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       rq;
    logic       start;
    logic [1:0] mode;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic       gnt_a, rdy_a, oe_a;
    logic [7:0] rdata_a;
    logic       gnt_b, rdy_b, oe_b;
    logic [7:0] rdata_b;

    logic       sel;     // 0: WAIT_STATES=1 instance, 1: WAIT_STATES=0 instance
    logic       gnt, rdy, oe;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [256];
    logic [7:0] exp_q [$];

`ifdef MEM_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_bus_responder #(.DWIDTH(8), .AWIDTH(8), .WAIT_STATES(1), .BURST_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .rq(rq), .start(start), .mode(mode), .addr(addr),
        .wdata(wdata), .gnt(gnt_a), .rdy(rdy_a), .rdata(rdata_a), .rdata_oe(oe_a)
    );

    mem_bus_responder #(.DWIDTH(8), .AWIDTH(8), .WAIT_STATES(0), .BURST_LEN(4)) dut_b (
        .clk(clk), .rst(rst), .rq(rq), .start(start), .mode(mode), .addr(addr),
        .wdata(wdata), .gnt(gnt_b), .rdy(rdy_b), .rdata(rdata_b), .rdata_oe(oe_b)
    );

    assign gnt   = sel ? gnt_b   : gnt_a;
    assign rdy   = sel ? rdy_b   : rdy_a;
    assign oe    = sel ? oe_b    : oe_a;
    assign rdata = sel ? rdata_b : rdata_a;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  addr;
        logic [31:0] data;   // beat 0 in the top byte
        bit          hold;   // keep rq high through the transfer
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int beats_of(input logic [1:0] m);
        return (BURST_EN && m[1]) ? 4 : 1;
    endfunction

    // One complete transfer, entered and left on a negedge; checks the exact
    // cycle-by-cycle gnt/rdy/rdata_oe pattern and read data via the scoreboard.
    task automatic do_xfer(input int ws, input logic [1:0] m, input logic [7:0] a,
                           input logic [31:0] dw, input bit hold);
        int         n;
        int         b;
        bit         active;
        logic [7:0] ba;
        logic [7:0] byte_v;
        logic [7:0] exp_v;
        n = beats_of(m);
        check("gnt_low_before_grant", gnt, 1'b0);
        rq = 1'b1;
        @(negedge clk);
        check("gnt_granted", gnt, 1'b1);
        check("rdy_in_grant", rdy, 1'b0);
        start = 1'b1;
        mode  = m;
        addr  = a;
        if (!m[0]) begin
            for (int i = 0; i < n; i++) begin
                ba = a + 8'(i);
                exp_q.push_back(model_mem[ba]);
            end
        end
        for (int k = 1; k <= ws + n + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                mode  = ~m;      // must be ignored after accept
                addr  = ~a;
                if (!hold) rq = 1'b0;
            end
            active = (k > ws) && (k <= ws + n);
            b      = k - ws - 1;
            check("gnt_xfer", gnt, (k <= ws + n));
            check("rdy_beat", rdy, active);
            check("rdata_oe", oe, active && !m[0]);
            if (active && !m[0]) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rdata", rdata, exp_v);
                end
            end
            if (active && m[0]) begin
                byte_v = dw[31 - 8*b -: 8];
                ba     = a + 8'(b);
                wdata  = byte_v;
                model_mem[ba] = byte_v;
            end
        end
    endtask

    // Write transfer (WAIT_STATES=1) with rst raised during beat rbeat.
    task automatic reset_mid(input logic [1:0] m, input logic [7:0] a,
                             input logic [31:0] dw, input int rbeat);
        int         b;
        logic [7:0] ba;
        rq = 1'b1;
        @(negedge clk);
        check("rm_gnt", gnt, 1'b1);
        start = 1'b1;
        mode  = m;
        addr  = a;
        for (int k = 1; k <= rbeat + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                rq    = 1'b0;
            end else begin
                b = k - 2;
                check("rm_rdy", rdy, 1'b1);
                wdata = dw[31 - 8*b -: 8];
                if (b < rbeat) begin
                    ba = a + 8'(b);
                    model_mem[ba] = wdata;
                end else begin
                    rst = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("rm_gnt_zero", gnt, 1'b0);
        check("rm_rdy_zero", rdy, 1'b0);
        check("rm_oe_zero", oe, 1'b0);
        check("rm_rdata_zero", rdata, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("rm_idle_gnt", gnt, 1'b0);
    endtask

    initial begin
        foreach (model_mem[i]) model_mem[i] = 8'h00;
        vecs[0]  = '{2'b01, 8'h10, 32'hA5000000, 1'b0};
        vecs[1]  = '{2'b00, 8'h10, 32'h00000000, 1'b0};
        vecs[2]  = '{2'b01, 8'h20, 32'h3C000000, 1'b1};
        vecs[3]  = '{2'b01, 8'hFF, 32'hC3000000, 1'b0};
        vecs[4]  = '{2'b00, 8'hFF, 32'h00000000, 1'b0};
        vecs[5]  = '{2'b01, 8'h00, 32'h99000000, 1'b0};
        vecs[6]  = '{2'b11, 8'hFE, 32'h11223344, 1'b0};
        vecs[7]  = '{2'b10, 8'hFE, 32'h00000000, 1'b0};
        vecs[8]  = '{2'b00, 8'h00, 32'h00000000, 1'b1};
        vecs[9]  = '{2'b00, 8'h20, 32'h00000000, 1'b0};
        vecs[10] = '{2'b01, 8'h02, 32'h5A000000, 1'b0};
        vecs[11] = '{2'b00, 8'h02, 32'h00000000, 1'b0};

        sel = 1'b0; rst = 1'b1; rq = 1'b0; start = 1'b0;
        mode = 2'b00; addr = 8'h00; wdata = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_gnt", gnt, 1'b0);
        check("reset_rdy", rdy, 1'b0);
        check("reset_oe", oe, 1'b0);
        check("reset_rdata", rdata, 8'h00);
        rst = 1'b0;

        // start outside GRANT is ignored
        start = 1'b1; mode = 2'b01; addr = 8'h33;
        @(negedge clk);
        start = 1'b0;
        check("stray_start_gnt", gnt, 1'b0);
        @(negedge clk);
        check("stray_start_rdy", rdy, 1'b0);
        check("stray_start_gnt2", gnt, 1'b0);

        // Table-driven transfers
        for (int v = 0; v < 12; v++) begin
            do_xfer(1, vecs[v].mode, vecs[v].addr, vecs[v].data, vecs[v].hold);
        end

        // Abandon: grant then drop rq without start
        @(negedge clk);
        rq = 1'b1;
        @(negedge clk);
        check("abandon_gnt", gnt, 1'b1);
        rq = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abandon_gnt_low", gnt, 1'b0);
            check("abandon_no_rdy", rdy, 1'b0);
        end

        // Reset mid-transfer: the beat at the reset edge must not reach 0x02
        if (BURST_EN) reset_mid(2'b11, 8'h00, 32'h778899AA, 2);
        else          reset_mid(2'b01, 8'h02, 32'h77000000, 0);
        do_xfer(1, 2'b00, 8'h02, 32'h0, 1'b0);
        do_xfer(1, 2'b00, 8'h00, 32'h0, 1'b0);

        // Back-to-back with rq held on the WAIT_STATES=0 instance
        rst = 1'b1;
        sel = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        do_xfer(0, 2'b11, 8'h40, 32'h5EA1B2C3, 1'b1);
        do_xfer(0, 2'b10, 8'h40, 32'h0, 1'b1);
        do_xfer(0, 2'b01, 8'h7F, 32'hE7000000, 1'b1);
        do_xfer(0, 2'b00, 8'h7F, 32'h0, 1'b0);
        @(negedge clk);
        check("b2b_idle_gnt", gnt, 1'b0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
